// File: rtl/mcpu_mem_arb.sv
// mcpu_mem_arb: serialises the two mem2dc request ports onto the shared RAM port and the
// MMIO port, with fixed port-0 priority, a port-1 starvation guard and registered outputs.
module mcpu_mem_arb #(
  parameter int unsigned RAM_LATENCY  = 1,
  parameter int unsigned MMIO_BIT     = 29,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst,
  input  logic [29:0] mem2dc_paddr0,
  input  logic [29:0] mem2dc_paddr1,
  input  logic [3:0]  mem2dc_write0,
  input  logic [3:0]  mem2dc_write1,
  input  logic        mem2dc_valid0,
  input  logic        mem2dc_valid1,
  input  logic [31:0] mem2dc_data_out0,
  input  logic [31:0] mem2dc_data_out1,
  output logic        mem2dc_done0,
  output logic        mem2dc_done1,
  output logic [31:0] mem2dc_data_in0,
  output logic [31:0] mem2dc_data_in1,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byteen,
  output logic        ram_wren,
  output logic        ram_clken,
  input  logic [31:0] ram_q,
  output logic [28:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_wren,
  input  logic [31:0] mmio_q
);

  localparam int unsigned STARVE_W = (STARVE_LIMIT < 32'd1) ? 32'd1 : $clog2(STARVE_LIMIT + 32'd1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(32'd1);
  localparam logic [1:0] WAIT_INIT = (RAM_LATENCY > 32'd1) ? 2'(RAM_LATENCY - 32'd2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic [3:0]          write_q, write_d;
  logic                is_mmio_q, is_mmio_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [1:0]          wait_q, wait_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [13:0]         ram_addr_q, ram_addr_d;
  logic [31:0]         ram_wdata_q, ram_wdata_d;
  logic [3:0]          ram_byteen_q, ram_byteen_d;
  logic                ram_wren_q, ram_wren_d;
  logic                ram_clken_q, ram_clken_d;
  logic [28:0]         mmio_addr_q, mmio_addr_d;
  logic [31:0]         mmio_wdata_q, mmio_wdata_d;
  logic [3:0]          mmio_wren_q, mmio_wren_d;

  logic                pick1_s;
  logic [29:0]         sel_paddr_s;
  logic [3:0]          sel_write_s;
  logic [31:0]         sel_data_s;
  logic                sel_mmio_s;
  logic                finish_s;

  // Port 1 wins only when port 0 is idle or port 1 has waited through STARVE_LIMIT grants.
  assign pick1_s     = mem2dc_valid1 && (!mem2dc_valid0 || (starve_q == STARVE_MAX));
  assign sel_paddr_s = pick1_s ? mem2dc_paddr1 : mem2dc_paddr0;
  assign sel_write_s = pick1_s ? mem2dc_write1 : mem2dc_write0;
  assign sel_data_s  = pick1_s ? mem2dc_data_out1 : mem2dc_data_out0;
  assign sel_mmio_s  = sel_paddr_s[MMIO_BIT];
  assign finish_s    = ((state_q == S_ISSUE) && (RAM_LATENCY == 32'd1)) ||
                       ((state_q == S_WAIT) && (wait_q == 2'd0));

  // Next-state, arbitration and output decode.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    write_d      = write_q;
    is_mmio_d    = is_mmio_q;
    starve_d     = starve_q;
    wait_d       = wait_q;
    rdata_d      = rdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    ram_addr_d   = 14'd0;
    ram_wdata_d  = 32'd0;
    ram_byteen_d = 4'd0;
    ram_wren_d   = 1'b0;
    ram_clken_d  = 1'b0;
    mmio_addr_d  = 29'd0;
    mmio_wdata_d = 32'd0;
    mmio_wren_d  = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (!mem2dc_valid1) begin
          starve_d = {STARVE_W{1'b0}};
        end else if (pick1_s) begin
          starve_d = {STARVE_W{1'b0}};
        end else if (mem2dc_valid0 && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + STARVE_ONE;
        end else begin
          starve_d = starve_q;
        end

        if (mem2dc_valid0 || mem2dc_valid1) begin
          grant_d   = pick1_s;
          write_d   = sel_write_s;
          is_mmio_d = sel_mmio_s;
          state_d   = S_ISSUE;
          if (sel_mmio_s) begin
            mmio_addr_d  = sel_paddr_s[28:0];
            mmio_wdata_d = sel_data_s;
            mmio_wren_d  = sel_write_s;
          end else begin
            ram_clken_d  = 1'b1;
            ram_addr_d   = sel_paddr_s[13:0];
            ram_wdata_d  = sel_data_s;
            ram_byteen_d = sel_write_s;
            ram_wren_d   = (sel_write_s != 4'd0);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (RAM_LATENCY == 32'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = S_DONE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Capture happens even for an aborted request; only the done pulse is gated by valid.
    if (finish_s) begin
      rdata_d = (write_q != 4'd0) ? 32'd0 : (is_mmio_q ? mmio_q : ram_q);
      done0_d = !grant_q && mem2dc_valid0;
      done1_d = grant_q && mem2dc_valid1;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, transaction latches and registered outputs.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      write_q      <= 4'd0;
      is_mmio_q    <= 1'b0;
      starve_q     <= {STARVE_W{1'b0}};
      wait_q       <= 2'd0;
      rdata_q      <= 32'd0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      ram_addr_q   <= 14'd0;
      ram_wdata_q  <= 32'd0;
      ram_byteen_q <= 4'd0;
      ram_wren_q   <= 1'b0;
      ram_clken_q  <= 1'b0;
      mmio_addr_q  <= 29'd0;
      mmio_wdata_q <= 32'd0;
      mmio_wren_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      write_q      <= write_d;
      is_mmio_q    <= is_mmio_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
      rdata_q      <= rdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_byteen_q <= ram_byteen_d;
      ram_wren_q   <= ram_wren_d;
      ram_clken_q  <= ram_clken_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
      mmio_wren_q  <= mmio_wren_d;
    end
  end

  assign mem2dc_done0    = done0_q;
  assign mem2dc_done1    = done1_q;
  assign mem2dc_data_in0 = rdata_q;
  assign mem2dc_data_in1 = rdata_q;
  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign ram_byteen      = ram_byteen_q;
  assign ram_wren        = ram_wren_q;
  assign ram_clken       = ram_clken_q;
  assign mmio_addr       = mmio_addr_q;
  assign mmio_wdata      = mmio_wdata_q;
  assign mmio_wren       = mmio_wren_q;

endmodule

// File: tb/tb_mcpu_mem_arb.sv
// tb_mcpu_mem_arb: scoreboard bench for mcpu_mem_arb; a behavioural RAM/MMIO reference predicts
// read data per port, plus directed latency, priority, starvation, abort and reset scenarios.
`timescale 1ns/1ps
module tb_mcpu_mem_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [29:0] paddr [2];
  logic [3:0]  wr    [2];
  logic        valid [2];
  logic [31:0] wdat  [2];

  logic        done0, done1;
  logic [31:0] din0, din1;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_q;
  logic [3:0]  ram_byteen;
  logic        ram_wren, ram_clken;
  logic [28:0] mmio_addr;
  logic [31:0] mmio_wdata, mmio_q;
  logic [3:0]  mmio_wren;

  logic [31:0] ram_mem [16384];
  logic [31:0] ref_mem [16384];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          done_log [$];
  int          checks = 0;
  int          errors = 0;

  mcpu_mem_arb #(.RAM_LATENCY(1), .MMIO_BIT(29), .STARVE_LIMIT(4)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .mem2dc_paddr0   (paddr[0]),
    .mem2dc_paddr1   (paddr[1]),
    .mem2dc_write0   (wr[0]),
    .mem2dc_write1   (wr[1]),
    .mem2dc_valid0   (valid[0]),
    .mem2dc_valid1   (valid[1]),
    .mem2dc_data_out0(wdat[0]),
    .mem2dc_data_out1(wdat[1]),
    .mem2dc_done0    (done0),
    .mem2dc_done1    (done1),
    .mem2dc_data_in0 (din0),
    .mem2dc_data_in1 (din1),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_byteen      (ram_byteen),
    .ram_wren        (ram_wren),
    .ram_clken       (ram_clken),
    .ram_q           (ram_q),
    .mmio_addr       (mmio_addr),
    .mmio_wdata      (mmio_wdata),
    .mmio_wren       (mmio_wren),
    .mmio_q          (mmio_q)
  );

  function automatic logic [31:0] mmio_fn(input logic [28:0] a);
    return {a, 3'b101} ^ 32'hC3C3_1234;
  endfunction

  // Single-cycle RAM: q follows the address presented in the issue cycle; writes land at its end.
  assign ram_q  = ram_mem[ram_addr];
  assign mmio_q = mmio_fn(mmio_addr);

  initial begin : ram_model
    forever begin
      @(posedge clk);
      if (ram_clken && ram_wren) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteen[b]) ram_mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: update the shadow memory and predict the response of one request.
  task automatic model_req(input int p, input logic [29:0] a, input logic [3:0] w,
                           input logic [31:0] d, input bit push);
    logic [31:0] e;
    logic [13:0] ra;
    ra = a[13:0];
    e  = 32'd0;
    if (w == 4'd0) begin
      e = a[29] ? mmio_fn(a[28:0]) : ref_mem[ra];
    end else if (!a[29]) begin
      for (int b = 0; b < 4; b++) begin
        if (w[b]) ref_mem[ra][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    if (push) begin
      if (p == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
  endtask

  // Present a request, wait (bounded) for its done, then drop valid unless another follows.
  task automatic do_req(input int p, input logic [29:0] a, input logic [3:0] w,
                        input logic [31:0] d, input bit keep);
    bit seen;
    paddr[p] = a;
    wr[p]    = w;
    wdat[p]  = d;
    valid[p] = 1'b1;
    model_req(p, a, w, d, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      if ((p == 0) ? done0 : done1) seen = 1'b1;
    end
    chk($sformatf("done_in_time_p%0d", p), 32'(seen), 32'd1);
    if (!keep) valid[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [29:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic [12:0] idx;
    logic [31:0] pv;
    bit          keep;
    pv = 32'(p);
    for (int k = 0; k < n; k++) begin
      idx      = 13'($urandom_range(8191, 128));
      a[13:0]  = {idx, pv[0]};
      a[28:14] = 15'($urandom);
      a[29]    = ($urandom_range(3, 0) == 0);
      w        = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
      d        = $urandom;
      keep     = ($urandom_range(2, 0) == 0) && (k != n - 1);
      do_req(p, a, w, d, keep);
      if (!keep) repeat ($urandom_range(3, 1)) @(negedge clk);
    end
  endtask

  // Monitor: pops the per-port expectation whenever a done pulse appears.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done0 || done1) chk("done_onehot", 32'(done0 & done1), 32'd0);
        if (ram_clken || (mmio_wren != 4'd0))
          chk("target_exclusive", 32'(ram_clken & (mmio_wren != 4'd0)), 32'd0);
        if (done0) begin
          if (exp_q0.size() == 0) chk("done0_unexpected", 32'(exp_q0.size()), 32'd1);
          else begin
            e = exp_q0.pop_front();
            chk("rdata_port0", din0, e);
            chk("rdata_port0_on_in1", din1, e);
            done_log.push_back(0);
          end
        end
        if (done1) begin
          if (exp_q1.size() == 0) chk("done1_unexpected", 32'(exp_q1.size()), 32'd1);
          else begin
            e = exp_q1.pop_front();
            chk("rdata_port1", din1, e);
            chk("rdata_port1_on_in0", din0, e);
            done_log.push_back(1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int exp_order [6];
    exp_order = '{0, 0, 0, 0, 1, 0};
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      paddr[p] = 30'd0; wr[p] = 4'd0; valid[p] = 1'b0; wdat[p] = 32'd0;
    end
    for (int i = 0; i < 16384; i++) begin
      ram_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_A5A5;
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_A5A5;
    end
    ram_mem[16] = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_din0", din0, 32'd0);
    chk("rst_ram_clken", 32'(ram_clken), 32'd0);
    chk("rst_mmio_wren", 32'(mmio_wren), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Port-0 read: issue at N+1, done with data at N+2.
    paddr[0] = 30'h0000_0010; wr[0] = 4'd0; valid[0] = 1'b1;
    model_req(0, paddr[0], 4'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("t1_ram_clken", 32'(ram_clken), 32'd1);
    chk("t1_ram_addr", 32'(ram_addr), 32'h10);
    chk("t1_done0_early", 32'(done0), 32'd0);
    @(negedge clk);
    chk("t1_done0", 32'(done0), 32'd1);
    chk("t1_din0", din0, 32'hDEAD_BEEF);
    valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_done0_pulse", 32'(done0), 32'd0);

    // Simultaneous write (port 0) and read (port 1) of the same word.
    paddr[0] = 30'h20; wr[0] = 4'hF; wdat[0] = 32'h1234_5678; valid[0] = 1'b1;
    model_req(0, 30'h20, 4'hF, 32'h1234_5678, 1'b1);
    paddr[1] = 30'h20; wr[1] = 4'd0; wdat[1] = 32'd0; valid[1] = 1'b1;
    model_req(1, 30'h20, 4'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("t2_ram_wren", 32'(ram_wren), 32'd1);
    chk("t2_ram_byteen", 32'(ram_byteen), 32'hF);
    chk("t2_ram_wdata", ram_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("t2_done0", 32'(done0), 32'd1);
    chk("t2_done1_n2", 32'(done1), 32'd0);
    valid[0] = 1'b0;
    @(negedge clk);
    chk("t2_bubble_clken", 32'(ram_clken), 32'd0);
    @(negedge clk);
    chk("t2_p1_issue", 32'(ram_clken), 32'd1);
    chk("t2_p1_rd", 32'(ram_wren), 32'd0);
    @(negedge clk);
    chk("t2_done1", 32'(done1), 32'd1);
    chk("t2_din1", din1, 32'h1234_5678);
    valid[1] = 1'b0;
    @(negedge clk);

    // MMIO write from port 1.
    paddr[1] = 30'h2000_0004; wr[1] = 4'h3; wdat[1] = 32'hAABB_CCDD; valid[1] = 1'b1;
    model_req(1, 30'h2000_0004, 4'h3, 32'hAABB_CCDD, 1'b1);
    @(negedge clk);
    chk("t3_mmio_wren", 32'(mmio_wren), 32'h3);
    chk("t3_mmio_addr", 32'(mmio_addr), 32'h4);
    chk("t3_mmio_wdata", mmio_wdata, 32'hAABB_CCDD);
    chk("t3_ram_idle", {30'd0, ram_wren, ram_clken}, 32'd0);
    @(negedge clk);
    chk("t3_done1", 32'(done1), 32'd1);
    chk("t3_mmio_wren_off", 32'(mmio_wren), 32'd0);
    valid[1] = 1'b0;
    @(negedge clk);

    // Starvation guard: four port-0 grants, then port 1, then port 0 again.
    done_log.delete();
    fork
      begin
        for (int k = 0; k < 5; k++)
          do_req(0, 30'(32'h100 + 32'(k) * 32'd2), 4'd0, 32'd0, (k < 4));
      end
      begin
        do_req(1, 30'h0000_0121, 4'd0, 32'd0, 1'b0);
      end
    join
    chk("t4_grant_count", 32'(done_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < done_log.size(); i++)
      chk($sformatf("t4_grant_order_%0d", i), 32'(done_log[i]), 32'(exp_order[i]));
    @(negedge clk);

    // Aborted write: RAM still written, no done, FSM back in IDLE on schedule.
    paddr[0] = 30'h40; wr[0] = 4'hF; wdat[0] = 32'h0BAD_F00D; valid[0] = 1'b1;
    model_req(0, 30'h40, 4'hF, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    chk("t5_ram_wren", 32'(ram_wren), 32'd1);
    valid[0] = 1'b0;
    @(negedge clk);
    chk("t5_no_done0", 32'(done0), 32'd0);
    chk("t5_rdata_updated", din0, 32'd0);
    @(negedge clk);
    paddr[0] = 30'h40; wr[0] = 4'd0; valid[0] = 1'b1;
    model_req(0, 30'h40, 4'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("t5_followup_issue", 32'(ram_clken), 32'd1);
    @(negedge clk);
    chk("t5_followup_done", 32'(done0), 32'd1);
    chk("t5_followup_data", din0, 32'h0BAD_F00D);
    valid[0] = 1'b0;
    @(negedge clk);

    // Reset during the issue cycle of a write.
    paddr[0] = 30'h50; wr[0] = 4'hF; wdat[0] = 32'hCAFE_F00D; valid[0] = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_wren_before", 32'(ram_wren), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_wren_async", 32'(ram_wren), 32'd0);
    chk("t6_ram_outs", {ram_wdata[17:0], ram_addr}, 32'd0);
    chk("t6_ram_ctl", {26'd0, ram_byteen, ram_clken, mmio_wren != 4'd0}, 32'd0);
    chk("t6_din0", din0, 32'd0);
    chk("t6_done", {30'd0, done1, done0}, 32'd0);
    valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    paddr[1] = 30'h21; wr[1] = 4'd0; valid[1] = 1'b1;
    model_req(1, 30'h21, 4'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("t6_post_issue", 32'(ram_addr), 32'h21);
    @(negedge clk);
    chk("t6_post_done1", 32'(done1), 32'd1);
    valid[1] = 1'b0;
    @(negedge clk);

    // Randomised traffic from both ports on disjoint RAM words plus MMIO.
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) @(negedge clk);
    chk("sb_port0_drained", 32'(exp_q0.size()), 32'd0);
    chk("sb_port1_drained", 32'(exp_q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
